regfile_mp_bypass: RTL and testbench

// Parametrised multi-port register file for the pipelined CPU. It succeeds the fixed 3R/1W, 16x32 file.

---
 rtl/regfile_pkg.sv | 12 +
 rtl/regfile_mp_bypass_if.sv | 27 ++
 rtl/rf_scoreboard.sv | 35 +++
 rtl/regfile_mp_bypass.sv | 84 ++++++++
 tb/tb_regfile_mp_bypass.sv | 132 +++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared defaults and types for the bypassing register file
package regfile_pkg;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 4;
  localparam int NUM_REGS = 16;
  localparam int NUM_RD   = 3;
  localparam int NUM_WR   = 2;
  localparam int PC_IDX   = NUM_REGS - 1;

  typedef logic [ADDR_W-1:0] reg_idx_t;
  typedef logic [DATA_W-1:0] word_t;
endpackage

// File: rtl/regfile_mp_bypass_if.sv
// rtl/regfile_mp_bypass_if.sv - decode/writeback side bundle of the register file
interface regfile_mp_bypass_if #(
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int ADDR_W = regfile_pkg::ADDR_W,
  parameter int NUM_RD = regfile_pkg::NUM_RD,
  parameter int NUM_WR = regfile_pkg::NUM_WR
);
  logic [NUM_WR-1:0]             we;
  logic [NUM_WR-1:0][ADDR_W-1:0] wa;
  logic [NUM_WR-1:0][DATA_W-1:0] wd;
  logic [DATA_W-1:0]             pc_plus8;
  logic [NUM_RD-1:0][ADDR_W-1:0] ra;
  logic [NUM_RD-1:0][DATA_W-1:0] rd;
  logic [NUM_RD-1:0]             rd_busy;
  logic                          iss_v;
  logic [ADDR_W-1:0]             iss_addr;

  modport master (
    output we, wa, wd, pc_plus8, ra, iss_v, iss_addr,
    input  rd, rd_busy
  );

  modport slave (
    input  we, wa, wd, pc_plus8, ra, iss_v, iss_addr,
    output rd, rd_busy
  );
endinterface

// File: rtl/rf_scoreboard.sv
// rtl/rf_scoreboard.sv - per-register busy bits; issue sets, writeback clears
module rf_scoreboard #(
  parameter int NUM_REGS = regfile_pkg::NUM_REGS,
  parameter int ADDR_W   = regfile_pkg::ADDR_W,
  parameter int NUM_WR   = regfile_pkg::NUM_WR
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_WR-1:0]             we,
  input  logic [NUM_WR-1:0][ADDR_W-1:0] wa,
  input  logic                          iss_v,
  input  logic [ADDR_W-1:0]             iss_addr,
  output logic [NUM_REGS-1:0]           busy_next
);
  logic [NUM_REGS-1:0] busy_q, busy_d;

  // Set is applied after clear so a new producer wins over a retiring one.
  always_comb begin
    busy_d = busy_q;
    for (int r = 0; r < NUM_REGS - 1; r++) begin
      for (int i = 0; i < NUM_WR; i++) begin
        if (we[i] && wa[i] == ADDR_W'(r)) busy_d[r] = 1'b0;
      end
      if (iss_v && iss_addr == ADDR_W'(r)) busy_d[r] = 1'b1;
    end
    busy_d[NUM_REGS-1] = 1'b0;
  end

  assign busy_next = busy_d;

  always_ff @(posedge clk) begin
    if (reset) busy_q <= '0;
    else       busy_q <= busy_d;
  end
endmodule

// File: rtl/regfile_mp_bypass.sv
// rtl/regfile_mp_bypass.sv - multi-port register file with write-to-read bypass and PC alias
module regfile_mp_bypass #(
  parameter int DATA_W   = regfile_pkg::DATA_W,
  parameter int ADDR_W   = regfile_pkg::ADDR_W,
  parameter int NUM_REGS = regfile_pkg::NUM_REGS,
  parameter int NUM_RD   = regfile_pkg::NUM_RD,
  parameter int NUM_WR   = regfile_pkg::NUM_WR
) (
  input logic               clk,
  input logic               reset,
  regfile_mp_bypass_if.slave bus
);
  localparam int PC_IDX = NUM_REGS - 1;

  // The PC index has no storage; it is always served from pc_plus8.
  logic [DATA_W-1:0]   rf_q [PC_IDX];
  logic [DATA_W-1:0]   rf_d [PC_IDX];
  logic [NUM_REGS-1:0] busy_next;

  rf_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W),
    .NUM_WR   (NUM_WR)
  ) u_scoreboard (
    .clk       (clk),
    .reset     (reset),
    .we        (bus.we),
    .wa        (bus.wa),
    .iss_v     (bus.iss_v),
    .iss_addr  (bus.iss_addr),
    .busy_next (busy_next)
  );

  always_comb begin
    rf_d = rf_q;
    for (int r = 0; r < PC_IDX; r++) begin
      for (int i = 0; i < NUM_WR; i++) begin
        if (bus.we[i] && bus.wa[i] == ADDR_W'(r)) rf_d[r] = bus.wd[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) rf_q <= '{default: '0};
    else       rf_q <= rf_d;
  end

  for (genvar j = 0; j < NUM_RD; j++) begin : g_rd
    logic [DATA_W-1:0] rd_d, rd_q;
    logic              busy_d, busy_q;

    always_comb begin
      rd_d   = '0;
      busy_d = 1'b0;
      if (int'(bus.ra[j]) == PC_IDX) begin
        rd_d = bus.pc_plus8;
      end else if (int'(bus.ra[j]) < NUM_REGS) begin
        for (int r = 0; r < PC_IDX; r++) begin
          if (bus.ra[j] == ADDR_W'(r)) begin
            rd_d   = rf_q[r];
            busy_d = busy_next[r];
          end
        end
        // Later ports overwrite earlier ones, matching the write priority.
        for (int i = 0; i < NUM_WR; i++) begin
          if (bus.we[i] && bus.wa[i] == bus.ra[j]) rd_d = bus.wd[i];
        end
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        rd_q   <= '0;
        busy_q <= 1'b0;
      end else begin
        rd_q   <= rd_d;
        busy_q <= busy_d;
      end
    end

    assign bus.rd[j]      = rd_q;
    assign bus.rd_busy[j] = busy_q;
  end
endmodule

// File: tb/tb_regfile_mp_bypass.sv
// tb/tb_regfile_mp_bypass.sv - directed vectors for default and swept configurations
module tb_regfile_mp_bypass;
  import regfile_pkg::*;

  logic clk = 1'b0;
  logic rst0, rst1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  regfile_mp_bypass_if #(.DATA_W(32), .ADDR_W(4), .NUM_RD(3), .NUM_WR(2)) if0 ();
  regfile_mp_bypass_if #(.DATA_W(64), .ADDR_W(4), .NUM_RD(4), .NUM_WR(1)) if1 ();

  regfile_mp_bypass #(
    .DATA_W(32), .ADDR_W(4), .NUM_REGS(16), .NUM_RD(3), .NUM_WR(2)
  ) dut0 (.clk(clk), .reset(rst0), .bus(if0.slave));

  regfile_mp_bypass #(
    .DATA_W(64), .ADDR_W(4), .NUM_REGS(8), .NUM_RD(4), .NUM_WR(1)
  ) dut1 (.clk(clk), .reset(rst1), .bus(if1.slave));

  typedef struct {
    string      name;
    logic       rst;
    logic [1:0] we;
    reg_idx_t   wa0;
    word_t      wd0;
    reg_idx_t   wa1;
    word_t      wd1;
    reg_idx_t   ra0, ra1, ra2;
    word_t      pc;
    logic       iv;
    reg_idx_t   ia;
    word_t      e0, e1, e2;
    logic [2:0] eb;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do1(input string name, input logic rst, input logic we, input reg_idx_t wa,
                     input logic [63:0] wd, input reg_idx_t r0, input reg_idx_t r1,
                     input reg_idx_t r2, input reg_idx_t r3, input logic [63:0] pc,
                     input logic iv, input reg_idx_t ia, input logic [63:0] e0,
                     input logic [63:0] e1, input logic [63:0] e2, input logic [63:0] e3,
                     input logic [3:0] eb);
    rst1 = rst; if1.we = we; if1.wa[0] = wa; if1.wd[0] = wd;
    if1.ra[0] = r0; if1.ra[1] = r1; if1.ra[2] = r2; if1.ra[3] = r3;
    if1.pc_plus8 = pc; if1.iss_v = iv; if1.iss_addr = ia;
    @(negedge clk);
    chk({name, ".rd0"}, if1.rd[0], e0);
    chk({name, ".rd1"}, if1.rd[1], e1);
    chk({name, ".rd2"}, if1.rd[2], e2);
    chk({name, ".rd3"}, if1.rd[3], e3);
    chk({name, ".busy"}, 64'(if1.rd_busy), 64'(eb));
  endtask

  initial begin
    //            name            rst we    wa0 wd0           wa1 wd1     ra0 ra1 ra2 pc         iv ia  e0            e1            e2            eb
    vecs.push_back('{"rst",        1, 2'b00, 0, 0,            0, 0,       0,  0,  0, 32'h108,  0, 0,  0,            0,            0,            3'b000});
    vecs.push_back('{"byp_r3",     0, 2'b01, 3, 32'hDEADBEEF, 0, 0,       3,  0,  0, 32'h108,  0, 0,  32'hDEADBEEF, 0,            0,            3'b000});
    vecs.push_back('{"rst_r3",     1, 2'b00, 0, 0,            0, 0,       3,  0,  0, 32'h108,  0, 0,  0,            0,            0,            3'b000});
    vecs.push_back('{"post_rst_r3",0, 2'b00, 0, 0,            0, 0,       3,  0,  0, 32'h108,  0, 0,  0,            0,            0,            3'b000});
    vecs.push_back('{"byp_r5",     0, 2'b01, 5, 32'h12345678, 0, 0,       5,  0,  0, 32'h108,  0, 0,  32'h12345678, 0,            0,            3'b000});
    vecs.push_back('{"hold_r5",    0, 2'b00, 0, 0,            0, 0,       5,  3,  0, 32'h108,  0, 0,  32'h12345678, 0,            0,            3'b000});
    vecs.push_back('{"prio_r2",    0, 2'b11, 2, 32'hAAAA,     2, 32'h5555, 2, 2,  5, 32'h108,  0, 0,  32'h5555,     32'h5555,     32'h12345678, 3'b000});
    vecs.push_back('{"hold_r2",    0, 2'b00, 0, 0,            0, 0,       15, 5,  2, 32'h108,  0, 0,  32'h108,      32'h12345678, 32'h5555,     3'b000});
    vecs.push_back('{"wr_pc_drop", 0, 2'b11, 15, 32'hFFFF,    15, 32'hFFFF, 0, 15, 0, 32'h108, 0, 0,  0,            32'h108,      0,            3'b000});
    vecs.push_back('{"pc_after",   0, 2'b00, 0, 0,            0, 0,       0,  15, 0, 32'h10C,  0, 0,  0,            32'h10C,      0,            3'b000});
    vecs.push_back('{"iss_r7",     0, 2'b00, 0, 0,            0, 0,       7,  0,  0, 32'h108,  1, 7,  0,            0,            0,            3'b001});
    vecs.push_back('{"busy_r7",    0, 2'b00, 0, 0,            0, 0,       7,  7,  0, 32'h108,  0, 0,  0,            0,            0,            3'b011});
    vecs.push_back('{"clr_r7",     0, 2'b01, 7, 32'h77,       0, 0,       7,  7,  0, 32'h108,  0, 0,  32'h77,       32'h77,       0,            3'b000});
    vecs.push_back('{"set_beats",  0, 2'b10, 0, 0,            7, 32'h88,  7,  0,  0, 32'h108,  1, 7,  32'h88,       0,            0,            3'b001});
    vecs.push_back('{"busy_hold",  0, 2'b00, 0, 0,            0, 0,       7,  0,  0, 32'h108,  0, 0,  32'h88,       0,            0,            3'b001});
    vecs.push_back('{"iss_pc",     0, 2'b00, 0, 0,            0, 0,       15, 7,  0, 32'h108,  1, 15, 32'h108,      32'h88,       0,            3'b010});
    vecs.push_back('{"rst_mid",    1, 2'b01, 9, 32'h99,       0, 0,       9,  7,  0, 32'h108,  1, 9,  0,            0,            0,            3'b000});
    vecs.push_back('{"post_rst",   0, 2'b00, 0, 0,            0, 0,       9,  7,  2, 32'h108,  0, 0,  0,            0,            0,            3'b000});

    rst0 = 1'b1; rst1 = 1'b1;
    if0.we = '0; if0.wa = '0; if0.wd = '0; if0.ra = '0; if0.pc_plus8 = '0;
    if0.iss_v = 1'b0; if0.iss_addr = '0;
    if1.we = '0; if1.wa = '0; if1.wd = '0; if1.ra = '0; if1.pc_plus8 = '0;
    if1.iss_v = 1'b0; if1.iss_addr = '0;
    repeat (2) @(negedge clk);
    chk("reset.rd0", 64'(if0.rd), 64'd0);
    chk("reset.busy0", 64'(if0.rd_busy), 64'd0);
    chk("reset.rd1", 64'(if1.rd[0]), 64'd0);
    chk("reset.busy1", 64'(if1.rd_busy), 64'd0);

    foreach (vecs[k]) begin
      rst0 = vecs[k].rst; if0.we = vecs[k].we;
      if0.wa[0] = vecs[k].wa0; if0.wd[0] = vecs[k].wd0;
      if0.wa[1] = vecs[k].wa1; if0.wd[1] = vecs[k].wd1;
      if0.ra[0] = vecs[k].ra0; if0.ra[1] = vecs[k].ra1; if0.ra[2] = vecs[k].ra2;
      if0.pc_plus8 = vecs[k].pc; if0.iss_v = vecs[k].iv; if0.iss_addr = vecs[k].ia;
      @(negedge clk);
      chk({vecs[k].name, ".rd0"}, 64'(if0.rd[0]), 64'(vecs[k].e0));
      chk({vecs[k].name, ".rd1"}, 64'(if0.rd[1]), 64'(vecs[k].e1));
      chk({vecs[k].name, ".rd2"}, 64'(if0.rd[2]), 64'(vecs[k].e2));
      chk({vecs[k].name, ".busy"}, 64'(if0.rd_busy), 64'(vecs[k].eb));
    end

    // Swept configuration: 8 regs (PC = 7), one write port, four read ports, 64-bit data.
    do1("c1_rst", 1, 0, 0, 0, 0, 0, 0, 0, 64'h1_0000_0108, 0, 0, 0, 0, 0, 0, 4'b0000);
    do1("c1_byp_r3", 0, 1, 3, 64'hDEADBEEF_CAFEF00D, 3, 0, 0, 0, 64'h1_0000_0108, 0, 0,
        64'hDEADBEEF_CAFEF00D, 0, 0, 0, 4'b0000);
    do1("c1_rst_r3", 1, 0, 0, 0, 3, 0, 0, 0, 64'h1_0000_0108, 0, 0, 0, 0, 0, 0, 4'b0000);
    do1("c1_post_rst", 0, 0, 0, 0, 3, 0, 0, 0, 64'h1_0000_0108, 0, 0, 0, 0, 0, 0, 4'b0000);
    do1("c1_byp_r5", 0, 1, 5, 64'h0123_4567_89AB_CDEF, 0, 5, 0, 0, 64'h1_0000_0108, 0, 0,
        0, 64'h0123_4567_89AB_CDEF, 0, 0, 4'b0000);
    do1("c1_pc", 0, 0, 0, 0, 0, 5, 7, 0, 64'h1_0000_0108, 0, 0,
        0, 64'h0123_4567_89AB_CDEF, 64'h1_0000_0108, 0, 4'b0000);
    do1("c1_wr_pc", 0, 1, 7, 64'hFFFF, 0, 0, 7, 0, 64'h1_0000_0110, 0, 0,
        0, 0, 64'h1_0000_0110, 0, 4'b0000);
    do1("c1_iss_r6", 0, 0, 0, 0, 0, 0, 0, 6, 64'h108, 1, 6, 0, 0, 0, 0, 4'b1000);
    do1("c1_clr_r6", 0, 1, 6, 64'h66, 0, 0, 0, 6, 64'h108, 0, 0, 0, 0, 0, 64'h66, 4'b0000);
    do1("c1_set_beats", 0, 1, 6, 64'h67, 0, 0, 0, 6, 64'h108, 1, 6, 0, 0, 0, 64'h67, 4'b1000);
    do1("c1_oob9", 0, 1, 9, 64'h99, 9, 0, 0, 6, 64'h108, 1, 9, 0, 0, 0, 64'h67, 4'b1000);
    do1("c1_oob8", 0, 0, 0, 0, 8, 9, 0, 6, 64'h108, 0, 0, 0, 0, 0, 64'h67, 4'b1000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
